ppu_oam_dma: RTL

PPU_OAM_DMA -- requirements
Module: ppu_oam_dma

---
 rtl/ppu_oam_dma_if.sv | 28 ++
 rtl/ppu_oam_dma.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ppu_oam_dma_if.sv
// Signal bundle for the OAM DMA engine: CPU trigger, CPU-bus read port,
// sprite RAM write port and status. The DMA side uses the slave modport.
interface ppu_oam_dma_if;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic [7:0]  oam_base;
    logic        cpu_odd_cycle;
    logic        sprite_load_busy;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_in;
    logic [7:0]  spram_wr_addr;
    logic [7:0]  spram_wr_data;
    logic        spram_wr_en;
    logic        cpu_halt;
    logic        busy;
    logic        done;

    modport master (
        output dma_start, dma_page, oam_base, cpu_odd_cycle, sprite_load_busy, mem_data_in,
        input  mem_addr, mem_rd, spram_wr_addr, spram_wr_data, spram_wr_en, cpu_halt, busy, done
    );

    modport slave (
        input  dma_start, dma_page, oam_base, cpu_odd_cycle, sprite_load_busy, mem_data_in,
        output mem_addr, mem_rd, spram_wr_addr, spram_wr_data, spram_wr_en, cpu_halt, busy, done
    );
endinterface

// File: rtl/ppu_oam_dma.sv
// NES $4014 OAM DMA: copies one CPU page into sprite RAM, three cycles per byte.
// Define OAM_DMA_ODD_ALIGN_EN to insert the odd-cycle alignment stall.
module ppu_oam_dma #(
    parameter int unsigned PAGE_BYTES = 256
) (
    input  logic           clk,
    input  logic           rst,
    ppu_oam_dma_if.slave   bus
);

    localparam int unsigned     CNT_W    = $clog2(PAGE_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUMMY   = 3'd1,
        S_ALIGN   = 3'd2,
        S_READ    = 3'd3,
        S_CAPTURE = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_buf_q, data_buf_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       base_q, base_d;
    logic             odd_q, odd_d;

    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             mem_rd_q, mem_rd_d;
    logic [7:0]       spram_wr_addr_q, spram_wr_addr_d;
    logic [7:0]       spram_wr_data_q, spram_wr_data_d;
    logic             spram_wr_en_q, spram_wr_en_d;
    logic             cpu_halt_q, cpu_halt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            data_buf_q      <= 8'h00;
            page_q          <= 8'h00;
            base_q          <= 8'h00;
            odd_q           <= 1'b0;
            mem_addr_q      <= 16'h0000;
            mem_rd_q        <= 1'b0;
            spram_wr_addr_q <= 8'h00;
            spram_wr_data_q <= 8'h00;
            spram_wr_en_q   <= 1'b0;
            cpu_halt_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            data_buf_q      <= data_buf_d;
            page_q          <= page_d;
            base_q          <= base_d;
            odd_q           <= odd_d;
            mem_addr_q      <= mem_addr_d;
            mem_rd_q        <= mem_rd_d;
            spram_wr_addr_q <= spram_wr_addr_d;
            spram_wr_data_q <= spram_wr_data_d;
            spram_wr_en_q   <= spram_wr_en_d;
            cpu_halt_q      <= cpu_halt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    // Next state; read strobe and status look ahead at state_d so they line up
    // with the state, while the write strobe follows the cycle that performed it.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        data_buf_d      = data_buf_q;
        page_d          = page_q;
        base_d          = base_q;
        odd_d           = odd_q;
        mem_addr_d      = mem_addr_q;
        mem_rd_d        = 1'b0;
        spram_wr_addr_d = spram_wr_addr_q;
        spram_wr_data_d = spram_wr_data_q;
        spram_wr_en_d   = 1'b0;
        cpu_halt_d      = 1'b0;
        busy_d          = 1'b0;
        done_d          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.dma_start) begin
                    page_d  = bus.dma_page;
                    base_d  = bus.oam_base;
`ifdef OAM_DMA_ODD_ALIGN_EN
                    odd_d   = bus.cpu_odd_cycle;
`else
                    odd_d   = 1'b0;
`endif
                    cnt_d   = '0;
                    state_d = S_DUMMY;
                end
            end
            S_DUMMY: begin
                state_d = odd_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_buf_d = bus.mem_data_in;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                // Sprite loader owns the RAM while busy; hold the byte until it frees up
                if (!bus.sprite_load_busy) begin
                    spram_wr_en_d   = 1'b1;
                    spram_wr_addr_d = base_q + 8'(cnt_q);
                    spram_wr_data_d = data_buf_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_READ) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {page_d, 8'(cnt_d)};
        end
        busy_d     = (state_d != S_IDLE);
        cpu_halt_d = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.spram_wr_addr = spram_wr_addr_q;
    assign bus.spram_wr_data = spram_wr_data_q;
    assign bus.spram_wr_en   = spram_wr_en_q;
    assign bus.cpu_halt      = cpu_halt_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule
